ps_to_mmv_dec: RTL and testbench
================================

Name: ps_to_mmv_dec

Overview:
- Decodes request packets from an inbound PacketStream into MemoryMapped master transactions with variable read latency.
- Returns each read result as a response packet on the outbound stream.
- Forms the far end of the stream link opposite the MemoryMapped-to-PacketStream encoder, sitting in front of a register file or bus slave.
- Word formats are identical to the encoder's:
  - Header bit0 is packet type: 0 = request, 1 = response.
  - Header bit1 is write request; header bit2 is read request; all other header bits are 0.

Parameters:
WIDTH, 8, address/data/stream word width (>= 3)

Ports:
rst  input  1  asynchronous reset, active-high
clk  input  1  clock
i_dat  input  WIDTH  inbound stream data
i_val  input  1  inbound valid
i_eop  input  1  inbound end of packet
i_rdy  output  1  inbound ready
o_dat  output  WIDTH  outbound stream data
o_val  output  1  outbound valid
o_eop  output  1  outbound end of packet
o_rdy  input  1  outbound ready
m_addr  output  WIDTH  master address
m_wreq  output  1  master write request
m_wdat  output  WIDTH  master write data
m_rreq  output  1  master read request
m_rdat  input  WIDTH  master read data
m_rval  input  1  master read data valid
m_busy  input  1  master busy (request not accepted)

Behaviour:
- Reset (rst, asynchronous, active-high):
  - m_wreq = m_rreq = o_val = o_eop = 0.
  - m_addr = m_wdat = o_dat = 0.
  - FSM = st_hdr, so i_rdy = 1.
  - A reset mid-transaction abandons it; no response is sent.
- Accepted word: i_val & i_rdy at a clk edge.
- i_rdy is a state decode: 1 in st_hdr, st_addr, st_data and st_skip; 0 otherwise.
- Packet format:
  - Request read: header (bit2=1), addr+eop.
  - Request write: header (bit1=1), addr, data+eop.
  - Response: header word value 1 (bit0=1, others 0), then rdat+eop.
- FSM states and transitions:
  - st_hdr:
    - Header with eop → stay in st_hdr (packet dropped).
    - bit0=1 → st_skip (response-type packet dropped).
    - bit1=1 → st_addr, op = write. bit1 takes priority if bits 1 and 2 are both set.
    - bit2=1 → st_addr, op = read.
    - Neither bit1 nor bit2 → st_skip.
  - st_addr: on accept, latch m_addr <= i_dat.
    - Write, eop=0 → st_data.
    - Write, eop=1 → st_hdr (dropped).
    - Read, eop=1 → st_rd, and m_rreq <= 1.
    - Read, eop=0 → st_skip (no read).
  - st_data: on accept, latch m_wdat <= i_dat.
    - eop=1 → st_wr, and m_wreq <= 1.
    - eop=0 → st_skip (no write).
  - st_skip: accept and discard words until an accepted eop, then st_hdr.
  - st_wr: m_wreq held with m_addr/m_wdat stable while m_busy=1.
    - At the edge with m_busy=0: m_wreq <= 0, go to st_hdr. No response is sent for writes.
  - st_rd: m_rreq held while m_busy=1.
    - At the edge with m_busy=0: m_rreq <= 0, go to st_rval.
  - st_rval:
    - m_rval is only sampled here, so the slave returns data >= 1 cycle after acceptance.
    - m_rval=1 → capture m_rdat into rdat_reg; o_dat <= 1, o_val <= 1, o_eop <= 0; go to st_res_hdr.
    - Wait is indefinite; there is no timeout.
  - st_res_hdr: on o_rdy → o_dat <= rdat_reg, o_eop <= 1; go to st_res_dat.
  - st_res_dat: on o_rdy → o_val <= 0, o_eop <= 0; go to st_hdr.
- All outputs except i_rdy are registered.
- No combinational path from o_rdy or m_busy to i_rdy.
- o_dat, o_eop and o_val hold stable while o_val=1 and o_rdy=0.
- Only one transaction is outstanding at a time. The inbound stream is stalled (i_rdy=0) from the end of a request packet until the write is accepted, or until the read response's final word is accepted.
- Latencies:
  - m_wreq/m_rreq assert 1 cycle after the last request word is accepted.
  - Response header is valid 1 cycle after m_rval.
  - Minimum read round trip from m_rval to the end of the response is 2 cycles with o_rdy=1.

Test Plan:
- Read: send 0x04, then 0x3A+eop; hold m_busy=0; drive m_rval with rdat 0x5C two cycles later.
  → m_rreq pulses 1 cycle with m_addr=0x3A. Outbound carries 0x01 then 0x5C+eop. i_rdy=0 until the 0x5C word is accepted.
- Write with stall: send 0x02, 0x10, 0xA5+eop; hold m_busy=1 for 3 cycles.
  → m_wreq=1 for 4 cycles with m_addr=0x10, m_wdat=0xA5. No outbound traffic. i_rdy returns the cycle after acceptance.
- Back-pressure: read as above with o_rdy=0 for 5 cycles.
  → o_dat=0x01, o_val=1, o_eop=0 held stable. Data word follows only after o_rdy=1.
- Malformed packets, each followed by a valid read:
  - header 0x01, 0xFF+eop;
  - header 0x00, 0x11+eop;
  - header 0x02, addr+eop;
  - header 0x04, 0x20, 0x21+eop.
  → No m_wreq/m_rreq for any malformed packet. The following read completes normally.
- Reset during st_rval: assert rst.
  → All outputs return to 0 immediately and i_rdy=1. A late m_rval is ignored and no response is emitted. The next read works.
- Both bits set: header 0x06, 0x08, 0x77+eop.
  → Handled as a write: m_wreq with m_addr=0x08, m_wdat=0x77; m_rreq stays 0.

Source files
------------

// File: rtl/ps_to_mmv_dec.sv
// ---------------------------------------------------------------------------
// ps_to_mmv_dec
//   PacketStream-to-MemoryMapped decoder. Inbound request packets are turned
//   into single MemoryMapped master transactions. Each read result is sent
//   back as a two-word response packet on the outbound stream. Only one
//   transaction is in flight at a time: the inbound stream is stalled from
//   the end of a request until the write is accepted or the read response
//   has been fully delivered.
//
//   Header word: bit0 = packet type (0 request, 1 response),
//                bit1 = write request, bit2 = read request.
//   Read request : header, addr+eop
//   Write request: header, addr, data+eop
//   Response     : 1, rdat+eop
//
// Ports
//   rst      async reset, active-high
//   clk      clock
//   i_dat    inbound stream data          i_val  inbound valid
//   i_eop    inbound end of packet        i_rdy  inbound ready (state decode)
//   o_dat    outbound stream data         o_val  outbound valid
//   o_eop    outbound end of packet       o_rdy  outbound ready
//   m_addr   master address               m_wreq master write request
//   m_wdat   master write data            m_rreq master read request
//   m_rdat   master read data             m_rval master read data valid
//   m_busy   master busy (request not accepted this cycle)
// ---------------------------------------------------------------------------
module ps_to_mmv_dec #(
   parameter int WIDTH = 8
) (
   input  logic             rst,
   input  logic             clk,
   input  logic [WIDTH-1:0] i_dat,
   input  logic             i_val,
   input  logic             i_eop,
   output logic             i_rdy,
   output logic [WIDTH-1:0] o_dat,
   output logic             o_val,
   output logic             o_eop,
   input  logic             o_rdy,
   output logic [WIDTH-1:0] m_addr,
   output logic             m_wreq,
   output logic [WIDTH-1:0] m_wdat,
   output logic             m_rreq,
   input  logic [WIDTH-1:0] m_rdat,
   input  logic             m_rval,
   input  logic             m_busy
);

   typedef enum logic [3:0] {
      st_hdr,
      st_addr,
      st_data,
      st_skip,
      st_wr,
      st_rd,
      st_rval,
      st_res_hdr,
      st_res_dat
   } state_t;

   localparam logic [WIDTH-1:0] RES_HDR = WIDTH'(1);

   state_t           state;
   logic             op_write;   // request being decoded is a write
   logic [WIDTH-1:0] rdat_reg;   // read result parked while the header goes out
   logic             acc;

   // NOTE: i_rdy decodes the state register only, so o_rdy and m_busy never
   // reach it combinationally; a continuous assign cannot infer a latch.
   assign i_rdy = (state == st_hdr)  || (state == st_addr) ||
                  (state == st_data) || (state == st_skip);

   assign acc = i_val & i_rdy;

   // NOTE: all state and outputs update with non-blocking assignments so every
   // branch sees the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= st_hdr;
         op_write <= 1'b0;
         rdat_reg <= '0;
         m_addr   <= '0;
         m_wdat   <= '0;
         m_wreq   <= 1'b0;
         m_rreq   <= 1'b0;
         o_dat    <= '0;
         o_val    <= 1'b0;
         o_eop    <= 1'b0;
      end else begin
         case (state)
            st_hdr: begin
               if (acc) begin
                  if (i_eop) begin
                     state <= st_hdr;              // one-word packet: drop
                  end else if (i_dat[0]) begin
                     state <= st_skip;             // response-type packet: drop
                  end else if (i_dat[1]) begin
                     state    <= st_addr;          // write wins over read
                     op_write <= 1'b1;
                  end else if (i_dat[2]) begin
                     state    <= st_addr;
                     op_write <= 1'b0;
                  end else begin
                     state <= st_skip;
                  end
               end
            end

            st_addr: begin
               if (acc) begin
                  m_addr <= i_dat;
                  if (op_write) begin
                     state <= i_eop ? st_hdr : st_data;
                  end else if (i_eop) begin
                     state  <= st_rd;
                     m_rreq <= 1'b1;
                  end else begin
                     state <= st_skip;
                  end
               end
            end

            st_data: begin
               if (acc) begin
                  m_wdat <= i_dat;
                  if (i_eop) begin
                     state  <= st_wr;
                     m_wreq <= 1'b1;
                  end else begin
                     state <= st_skip;             // over-long write: no access
                  end
               end
            end

            st_skip: begin
               if (acc && i_eop) begin
                  state <= st_hdr;
               end
            end

            st_wr: begin
               if (!m_busy) begin
                  m_wreq <= 1'b0;
                  state  <= st_hdr;
               end
            end

            st_rd: begin
               if (!m_busy) begin
                  m_rreq <= 1'b0;
                  state  <= st_rval;
               end
            end

            st_rval: begin
               if (m_rval) begin
                  rdat_reg <= m_rdat;
                  o_dat    <= RES_HDR;
                  o_val    <= 1'b1;
                  o_eop    <= 1'b0;
                  state    <= st_res_hdr;
               end
            end

            st_res_hdr: begin
               if (o_rdy) begin
                  o_dat <= rdat_reg;
                  o_eop <= 1'b1;
                  state <= st_res_dat;
               end
            end

            st_res_dat: begin
               if (o_rdy) begin
                  o_val <= 1'b0;
                  o_eop <= 1'b0;
                  state <= st_hdr;
               end
            end

            default: state <= st_hdr;
         endcase
      end
   end

endmodule

// File: tb/tb_ps_to_mmv_dec.sv
// ---------------------------------------------------------------------------
// tb_ps_to_mmv_dec
//   Directed bench for ps_to_mmv_dec (WIDTH = 8). Inputs are driven 1 ns after
//   each rising edge and outputs are compared at the same point, so every
//   observed value is the settled post-edge state. Expected values are
//   hand-derived from the packet protocol.
// ---------------------------------------------------------------------------
module tb_ps_to_mmv_dec;

   logic       rst;
   logic       clk;
   logic [7:0] i_dat;
   logic       i_val;
   logic       i_eop;
   logic       i_rdy;
   logic [7:0] o_dat;
   logic       o_val;
   logic       o_eop;
   logic       o_rdy;
   logic [7:0] m_addr;
   logic       m_wreq;
   logic [7:0] m_wdat;
   logic       m_rreq;
   logic [7:0] m_rdat;
   logic       m_rval;
   logic       m_busy;

   int vectors     = 0;
   int miscompares = 0;
   int wreq_cycles = 0;   // clock cycles with m_wreq high
   int rreq_cycles = 0;   // clock cycles with m_rreq high

   ps_to_mmv_dec #(.WIDTH(8)) dut (
      .rst    (rst),
      .clk    (clk),
      .i_dat  (i_dat),
      .i_val  (i_val),
      .i_eop  (i_eop),
      .i_rdy  (i_rdy),
      .o_dat  (o_dat),
      .o_val  (o_val),
      .o_eop  (o_eop),
      .o_rdy  (o_rdy),
      .m_addr (m_addr),
      .m_wreq (m_wreq),
      .m_wdat (m_wdat),
      .m_rreq (m_rreq),
      .m_rdat (m_rdat),
      .m_rval (m_rval),
      .m_busy (m_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Request strobes are sampled mid-cycle, away from the updating edge.
   always @(negedge clk) begin
      if (m_wreq === 1'b1) wreq_cycles++;
      if (m_rreq === 1'b1) rreq_cycles++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one inbound word; it is accepted at the next rising edge.
   task automatic send(input logic [7:0] dat, input logic eop);
      check("send i_rdy", 32'(i_rdy), 32'd1);
      i_dat = dat;
      i_eop = eop;
      i_val = 1'b1;
      step();
      i_val = 1'b0;
      i_eop = 1'b0;
      i_dat = 8'h00;
   endtask

   // Full read: request, one idle cycle in st_rval, then m_rval. The response
   // header is held for 'hold' cycles of o_rdy=0 before the data word.
   task automatic do_read(input logic [7:0] addr, input logic [7:0] rdat,
                          input int hold);
      int r0;
      int w0;
      r0 = rreq_cycles;
      w0 = wreq_cycles;
      send(8'h04, 1'b0);
      send(addr, 1'b1);
      check("rd m_rreq", 32'(m_rreq), 32'd1);
      check("rd m_addr", 32'(m_addr), 32'(addr));
      check("rd i_rdy stall", 32'(i_rdy), 32'd0);
      step();
      check("rd m_rreq drop", 32'(m_rreq), 32'd0);
      check("rd o_val idle", 32'(o_val), 32'd0);
      step();
      check("rd wait o_val", 32'(o_val), 32'd0);
      check("rd wait i_rdy", 32'(i_rdy), 32'd0);
      m_rval = 1'b1;
      m_rdat = rdat;
      if (hold > 0) o_rdy = 1'b0;
      step();
      m_rval = 1'b0;
      m_rdat = 8'h00;
      check("res hdr o_val", 32'(o_val), 32'd1);
      check("res hdr o_dat", 32'(o_dat), 32'h01);
      check("res hdr o_eop", 32'(o_eop), 32'd0);
      check("res hdr i_rdy", 32'(i_rdy), 32'd0);
      for (int k = 0; k < hold; k++) begin
         step();
         check("bp o_val", 32'(o_val), 32'd1);
         check("bp o_dat", 32'(o_dat), 32'h01);
         check("bp o_eop", 32'(o_eop), 32'd0);
      end
      o_rdy = 1'b1;
      step();
      check("res dat o_dat", 32'(o_dat), 32'(rdat));
      check("res dat o_eop", 32'(o_eop), 32'd1);
      check("res dat o_val", 32'(o_val), 32'd1);
      check("res dat i_rdy", 32'(i_rdy), 32'd0);
      step();
      check("res done o_val", 32'(o_val), 32'd0);
      check("res done o_eop", 32'(o_eop), 32'd0);
      check("res done i_rdy", 32'(i_rdy), 32'd1);
      check("rd m_rreq width", 32'(rreq_cycles - r0), 32'd1);
      check("rd no m_wreq", 32'(wreq_cycles - w0), 32'd0);
   endtask

   // Drive a malformed packet and confirm it triggers no master access.
   task automatic bad_packet(input string tag, input logic [7:0] w0,
                             input logic [7:0] w1, input logic [7:0] w2,
                             input int words);
      int r0;
      int q0;
      r0 = rreq_cycles;
      q0 = wreq_cycles;
      send(w0, 1'b0);
      send(w1, words == 2);
      if (words == 3) send(w2, 1'b1);
      step();
      check({tag, " m_rreq"}, 32'(rreq_cycles - r0), 32'd0);
      check({tag, " m_wreq"}, 32'(wreq_cycles - q0), 32'd0);
      check({tag, " i_rdy"}, 32'(i_rdy), 32'd1);
      check({tag, " o_val"}, 32'(o_val), 32'd0);
   endtask

   initial begin
      int w0;
      rst    = 1'b1;
      i_dat  = 8'h00;
      i_val  = 1'b0;
      i_eop  = 1'b0;
      o_rdy  = 1'b1;
      m_rdat = 8'h00;
      m_rval = 1'b0;
      m_busy = 1'b0;

      // Reset state
      #3;
      check("rst m_wreq", 32'(m_wreq), 32'd0);
      check("rst m_rreq", 32'(m_rreq), 32'd0);
      check("rst o_val", 32'(o_val), 32'd0);
      check("rst o_eop", 32'(o_eop), 32'd0);
      check("rst o_dat", 32'(o_dat), 32'h00);
      check("rst m_addr", 32'(m_addr), 32'h00);
      check("rst m_wdat", 32'(m_wdat), 32'h00);
      check("rst i_rdy", 32'(i_rdy), 32'd1);
      rst = 1'b0;
      step();

      // Basic read
      do_read(8'h3A, 8'h5C, 0);

      // Write with m_busy held for 3 cycles: m_wreq high for 4
      w0 = wreq_cycles;
      m_busy = 1'b1;
      send(8'h02, 1'b0);
      send(8'h10, 1'b0);
      send(8'hA5, 1'b1);
      for (int k = 0; k < 3; k++) begin
         check("wr m_wreq held", 32'(m_wreq), 32'd1);
         check("wr m_addr", 32'(m_addr), 32'h10);
         check("wr m_wdat", 32'(m_wdat), 32'hA5);
         check("wr i_rdy stall", 32'(i_rdy), 32'd0);
         check("wr o_val", 32'(o_val), 32'd0);
         step();
      end
      check("wr m_wreq last", 32'(m_wreq), 32'd1);
      m_busy = 1'b0;
      step();
      check("wr m_wreq drop", 32'(m_wreq), 32'd0);
      check("wr i_rdy back", 32'(i_rdy), 32'd1);
      check("wr m_wreq width", 32'(wreq_cycles - w0), 32'd4);
      check("wr no response", 32'(o_val), 32'd0);

      // Read with 5 cycles of outbound back-pressure
      do_read(8'h55, 8'hC7, 5);

      // Malformed packets, each followed by a valid read
      bad_packet("resp type", 8'h01, 8'hFF, 8'h00, 2);
      do_read(8'h01, 8'h9E, 0);
      bad_packet("no op", 8'h00, 8'h11, 8'h00, 2);
      do_read(8'h02, 8'h3F, 0);
      bad_packet("short wr", 8'h02, 8'h33, 8'h00, 2);
      do_read(8'h03, 8'hE1, 0);
      bad_packet("long rd", 8'h04, 8'h20, 8'h21, 3);
      do_read(8'h20, 8'h12, 0);

      // Header carrying eop is dropped alone
      w0 = rreq_cycles;
      send(8'h04, 1'b1);
      check("hdr eop m_rreq", 32'(rreq_cycles - w0), 32'd0);
      check("hdr eop i_rdy", 32'(i_rdy), 32'd1);
      do_read(8'h44, 8'hAA, 0);

      // Both op bits set: treated as a write
      w0 = rreq_cycles;
      send(8'h06, 1'b0);
      send(8'h08, 1'b0);
      send(8'h77, 1'b1);
      check("both m_wreq", 32'(m_wreq), 32'd1);
      check("both m_addr", 32'(m_addr), 32'h08);
      check("both m_wdat", 32'(m_wdat), 32'h77);
      check("both m_rreq", 32'(m_rreq), 32'd0);
      step();
      check("both m_wreq drop", 32'(m_wreq), 32'd0);
      check("both i_rdy", 32'(i_rdy), 32'd1);
      check("both no rd", 32'(rreq_cycles - w0), 32'd0);

      // Reset while waiting for m_rval
      send(8'h04, 1'b0);
      send(8'h5A, 1'b1);
      step();
      check("prerst i_rdy", 32'(i_rdy), 32'd0);
      check("prerst m_addr", 32'(m_addr), 32'h5A);
      #2;
      rst = 1'b1;
      #1;
      check("midrst m_addr", 32'(m_addr), 32'h00);
      check("midrst m_wdat", 32'(m_wdat), 32'h00);
      check("midrst o_val", 32'(o_val), 32'd0);
      check("midrst o_dat", 32'(o_dat), 32'h00);
      check("midrst m_rreq", 32'(m_rreq), 32'd0);
      check("midrst i_rdy", 32'(i_rdy), 32'd1);
      rst = 1'b0;
      m_rval = 1'b1;
      m_rdat = 8'hEE;
      step();
      step();
      check("late rval o_val", 32'(o_val), 32'd0);
      check("late rval i_rdy", 32'(i_rdy), 32'd1);
      m_rval = 1'b0;
      m_rdat = 8'h00;
      step();
      check("late rval still idle", 32'(o_val), 32'd0);
      do_read(8'h3C, 8'hC3, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
